// File: rtl/axi_w_router.sv
// ---------------------------------------------------------------------------
// axi_w_router
// Write-data channel router of the AXI interconnect. AXI4 W beats carry no ID,
// so every accepted AW handshake pushes a {master, slave} route into an
// in-order queue. The head route connects one master's W stream to one slave
// (or to a discard sink for decode errors) until the WLAST beat completes.
//
// Ports
//   clk, rstn               clock, asynchronous active-low reset
//   aw_push/aw_mst/aw_slv   accepted AW handshake and its decoded route
//   aw_full                 route queue full, AW must not handshake
//   w_busy                  route queue holds at least one route
//   W*_M0 / W*_M1           master-side W channels (WREADY is an output)
//   W*_S0 .. W*_S6          slave-side W channels (WREADY is an input)
// ---------------------------------------------------------------------------
module axi_w_router #(
    parameter int ROUTE_DEPTH = 2,
    parameter int DATA_W      = 32,
    parameter int STRB_W      = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              aw_push,
    input  logic              aw_mst,
    input  logic [2:0]        aw_slv,
    output logic              aw_full,
    output logic              w_busy,
    input  logic [DATA_W-1:0] WDATA_M0,
    input  logic [STRB_W-1:0] WSTRB_M0,
    input  logic              WLAST_M0,
    input  logic              WVALID_M0,
    output logic              WREADY_M0,
    input  logic [DATA_W-1:0] WDATA_M1,
    input  logic [STRB_W-1:0] WSTRB_M1,
    input  logic              WLAST_M1,
    input  logic              WVALID_M1,
    output logic              WREADY_M1,
    output logic [DATA_W-1:0] WDATA_S0,
    output logic [STRB_W-1:0] WSTRB_S0,
    output logic              WLAST_S0,
    output logic              WVALID_S0,
    input  logic              WREADY_S0,
    output logic [DATA_W-1:0] WDATA_S1,
    output logic [STRB_W-1:0] WSTRB_S1,
    output logic              WLAST_S1,
    output logic              WVALID_S1,
    input  logic              WREADY_S1,
    output logic [DATA_W-1:0] WDATA_S2,
    output logic [STRB_W-1:0] WSTRB_S2,
    output logic              WLAST_S2,
    output logic              WVALID_S2,
    input  logic              WREADY_S2,
    output logic [DATA_W-1:0] WDATA_S3,
    output logic [STRB_W-1:0] WSTRB_S3,
    output logic              WLAST_S3,
    output logic              WVALID_S3,
    input  logic              WREADY_S3,
    output logic [DATA_W-1:0] WDATA_S4,
    output logic [STRB_W-1:0] WSTRB_S4,
    output logic              WLAST_S4,
    output logic              WVALID_S4,
    input  logic              WREADY_S4,
    output logic [DATA_W-1:0] WDATA_S5,
    output logic [STRB_W-1:0] WSTRB_S5,
    output logic              WLAST_S5,
    output logic              WVALID_S5,
    input  logic              WREADY_S5,
    output logic [DATA_W-1:0] WDATA_S6,
    output logic [STRB_W-1:0] WSTRB_S6,
    output logic              WLAST_S6,
    output logic              WVALID_S6,
    input  logic              WREADY_S6
);

    localparam int PTR_W = (ROUTE_DEPTH > 1) ? $clog2(ROUTE_DEPTH) : 1;
    localparam int CNT_W = $clog2(ROUTE_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(ROUTE_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST_C = PTR_W'(ROUTE_DEPTH - 1);

    // Circular pointer advance; explicit wrap keeps ROUTE_DEPTH=1 correct.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_LAST_C) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              full_r;
    logic              busy_r;
    logic              mst_q_r [ROUTE_DEPTH];
    logic [2:0]        slv_q_r [ROUTE_DEPTH];

    logic              push_s;
    logic              pop_s;
    logic              head_mst_s;
    logic [2:0]        head_slv_s;
    logic              sel_valid_s;
    logic              sel_last_s;
    logic              sel_ready_s;
    logic [DATA_W-1:0] sel_data_s;
    logic [STRB_W-1:0] sel_strb_s;
    logic [6:0]        slv_ready_s;
    logic [6:0]        slv_valid_s;
    logic [1:0]        mst_ready_s;

    // A push while full is dropped; fullness is judged before any same-cycle pop.
    assign push_s = aw_push & ~full_r;
    assign pop_s  = busy_r & sel_valid_s & sel_ready_s & sel_last_s;

    assign aw_full = full_r;
    assign w_busy  = busy_r;

    assign slv_ready_s = {WREADY_S6, WREADY_S5, WREADY_S4, WREADY_S3,
                          WREADY_S2, WREADY_S1, WREADY_S0};

    // Next occupancy from the push/pop pair.
    always_comb begin
        cnt_nxt_s = cnt_r;
        case ({push_s, pop_s})
            2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
            2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Queue pointers, occupancy and the registered full/busy flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            cnt_r  <= cnt_nxt_s;
            full_r <= (cnt_nxt_s == DEPTH_C);
            busy_r <= (cnt_nxt_s != {CNT_W{1'b0}});
        end
    end

    // Route entry storage, written at the tail on an accepted push.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ROUTE_DEPTH; i++) begin
                mst_q_r[i] <= 1'b0;
                slv_q_r[i] <= 3'd0;
            end
        end else if (push_s) begin
            mst_q_r[wr_ptr_r] <= aw_mst;
            slv_q_r[wr_ptr_r] <= aw_slv;
        end
    end

    // Head-route steering: data/strb/last broadcast from the head master,
    // only WVALID is qualified per slave; slave index 7 is a discard sink.
    always_comb begin
        head_mst_s  = mst_q_r[rd_ptr_r];
        head_slv_s  = slv_q_r[rd_ptr_r];
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_ready_s = 1'b0;
        sel_data_s  = {DATA_W{1'b0}};
        sel_strb_s  = {STRB_W{1'b0}};
        slv_valid_s = 7'b0;
        mst_ready_s = 2'b00;
        if (busy_r) begin
            if (head_mst_s) begin
                sel_valid_s = WVALID_M1;
                sel_last_s  = WLAST_M1;
                sel_data_s  = WDATA_M1;
                sel_strb_s  = WSTRB_M1;
            end else begin
                sel_valid_s = WVALID_M0;
                sel_last_s  = WLAST_M0;
                sel_data_s  = WDATA_M0;
                sel_strb_s  = WSTRB_M0;
            end
            if (head_slv_s == 3'd7) begin
                sel_ready_s = 1'b1;
            end else begin
                sel_ready_s             = slv_ready_s[head_slv_s];
                slv_valid_s[head_slv_s] = sel_valid_s;
            end
            if (head_mst_s) begin
                mst_ready_s[1] = sel_ready_s;
            end else begin
                mst_ready_s[0] = sel_ready_s;
            end
        end else begin
            sel_ready_s = 1'b0;
        end
    end

    assign WREADY_M0 = mst_ready_s[0];
    assign WREADY_M1 = mst_ready_s[1];

    assign WVALID_S0 = slv_valid_s[0];
    assign WVALID_S1 = slv_valid_s[1];
    assign WVALID_S2 = slv_valid_s[2];
    assign WVALID_S3 = slv_valid_s[3];
    assign WVALID_S4 = slv_valid_s[4];
    assign WVALID_S5 = slv_valid_s[5];
    assign WVALID_S6 = slv_valid_s[6];

    assign WDATA_S0 = sel_data_s;  assign WSTRB_S0 = sel_strb_s;  assign WLAST_S0 = sel_last_s;
    assign WDATA_S1 = sel_data_s;  assign WSTRB_S1 = sel_strb_s;  assign WLAST_S1 = sel_last_s;
    assign WDATA_S2 = sel_data_s;  assign WSTRB_S2 = sel_strb_s;  assign WLAST_S2 = sel_last_s;
    assign WDATA_S3 = sel_data_s;  assign WSTRB_S3 = sel_strb_s;  assign WLAST_S3 = sel_last_s;
    assign WDATA_S4 = sel_data_s;  assign WSTRB_S4 = sel_strb_s;  assign WLAST_S4 = sel_last_s;
    assign WDATA_S5 = sel_data_s;  assign WSTRB_S5 = sel_strb_s;  assign WLAST_S5 = sel_last_s;
    assign WDATA_S6 = sel_data_s;  assign WSTRB_S6 = sel_strb_s;  assign WLAST_S6 = sel_last_s;

endmodule

// File: doc/axi_w_router.md
Name: axi_w_router

Overview:
- Write-data (W) channel router of the AXI interconnect: carries write beats from masters M0/M1 to slaves S0..S6.
- AXI4 W carries no ID, so the route comes from the AW channel. Each accepted AW handshake pushes a {master, slave} entry into an in-order route queue.
- The head entry connects one master's W stream to one slave until the WLAST beat completes.
- Sits beside the AW arbiter/decoder; the B response path is a separate block.

Parameters:
- ROUTE_DEPTH, 2, number of outstanding AW routes the queue holds (power of two, ≥1)
- DATA_W, 32, W data width (matches AXI_DATA_BITS)
- STRB_W, DATA_W/8, write strobe width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rstn  input  1  asynchronous active-low reset
- aw_push  input  1  AW handshake accepted this cycle; push route entry
- aw_mst  input  1  master index of the accepted AW (0=M0, 1=M1)
- aw_slv  input  3  decoded slave index 0..6; 7 = decode-error sink
- aw_full  output  1  route queue full; AW channel must not handshake while high
- w_busy  output  1  route queue non-empty
- WDATA_M0/M1  input  DATA_W  master write data
- WSTRB_M0/M1  input  STRB_W  master strobes
- WLAST_M0/M1  input  1  last beat of burst
- WVALID_M0/M1  input  1  master beat valid
- WREADY_M0/M1  output  1  beat accepted by router/slave
- WDATA_S0..S6  output  DATA_W  slave write data
- WSTRB_S0..S6  output  STRB_W  slave strobes
- WLAST_S0..S6  output  1  slave last-beat flag
- WVALID_S0..S6  output  1  slave beat valid
- WREADY_S0..S6  input  1  slave ready

Behaviour:
- Route queue: circular FIFO of ROUTE_DEPTH entries {mst[0], slv[2:0]}; rd/wr pointers plus count of width clog2(ROUTE_DEPTH)+1.
- aw_full = (count == ROUTE_DEPTH); w_busy = (count != 0). Both are combinational from registered count.
- Push: on aw_push && !aw_full, write entry at wr_ptr and advance it. aw_push while full is ignored: entry dropped, count unchanged.
- No same-cycle bypass: a route pushed into an empty queue takes effect the next cycle, so the earliest W handshake is 1 cycle after the AW handshake.
- Pop: on head-route handshake (selected WVALID_M && ready) with selected WLAST_M=1, advance rd_ptr.
- Push and pop in the same cycle: both occur, count unchanged. aw_full is evaluated before the pop, so a push while full is still ignored.
- Routing while count>0, with head {m, s}:
  - s in 0..6: WVALID_S[s] = WVALID_M[m]; WREADY_M[m] = WREADY_S[s].
  - s = 7 (sink): WREADY_M[m] = 1; beats are discarded; pop on WLAST.
  - WDATA/WSTRB/WLAST of every slave are driven from master m (broadcast); only WVALID is qualified.
  - WVALID of every non-selected slave = 0. WREADY of the non-selected master = 0; its WVALID is ignored and it stalls.
- While count==0: all WREADY_M=0, all WVALID_S=0, and all slave data, strobe and last outputs are 0.
- Ordering: W bursts are forwarded strictly in AW acceptance order, regardless of which master presents WVALID first.
- Beats between head pops are passed through unbuffered: zero added latency, no beat counting. Burst length is defined solely by WLAST.
- Reset: while rstn=0, pointers and count are cleared. aw_full=0, w_busy=0, all WREADY_M=0, all WVALID_S=0, slave data/strb/last=0.
  - Reset asserted mid-burst abandons the burst; no recovery beat is generated.
- No combinational path from aw_push/aw_mst/aw_slv to any W output.

Test Plan:
- Single burst: push {M0,S2} at cycle 0; M0 sends 4 beats, data 0x11..0x44, WLAST on 4th, S2 ready throughout. Expect:
  - WVALID_S2 high cycles 1-4 with matching data; no other WVALID_S asserted.
  - w_busy falls the cycle after the 4th beat.
- Ordering: push {M1,S4} then {M0,S0}; M0 asserts WVALID first. Expect:
  - WREADY_M0 = 0 until the M1 WLAST beat completes on S4.
  - Then M0's beats appear on S0 only.
- Backpressure: S3 holds WREADY low for 3 cycles mid-burst. Expect WREADY_M0 low those cycles and WDATA_S3 stable; burst completes with no loss or duplication.
- Full/simultaneous (ROUTE_DEPTH=2): push two routes, so aw_full=1. Then:
  - A push while full is dropped (count stays 2).
  - A push in the same cycle as the head's WLAST pop is also dropped.
  - A push the cycle after the pop is accepted (aw_full goes 1→0→1).
- Decode-error sink: push {M1,7}; M1 sends 2 beats. Expect WREADY_M1=1 for both beats, all WVALID_S=0, queue pops on WLAST.
- Reset mid-burst: assert rstn=0 after beat 2 of a 4-beat burst. Expect immediately: all WVALID_S=0, WREADY_M=0, w_busy=0. After release, a new push routes correctly.
